// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: conditions the PS/2 lines, deframes bytes, assembles
// 3/4-byte packets and tracks an absolute cursor clamped to the screen.
module ps2_mouse_rx #(
    parameter int PKT_BYTES   = 3,
    parameter int POS_W       = 16,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic              pkt_valid,
    output logic [2:0]        buttons,
    output logic [8:0]        dx,
    output logic [8:0]        dy,
    output logic [3:0]        wheel,
    output logic [POS_W-1:0]  x_pos,
    output logic [POS_W-1:0]  y_pos,
    output logic              err_parity,
    output logic              err_frame,
    output logic              err_timeout
);
    localparam int FILT_W = $clog2(FILT_LEN + 1);
    localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int SW     = POS_W + 2;
    localparam logic signed [SW-1:0] X_LIM = SW'(X_MAX);
    localparam logic signed [SW-1:0] Y_LIM = SW'(Y_MAX);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]        clk_sync, data_sync;
    logic              clk_filt, clk_filt_d;
    logic [FILT_W-1:0] filt_cnt;
    logic              fall_edge, data_s;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            clk_filt_d <= clk_filt;
            // The filtered level flips only after FILT_LEN disagreeing samples in a row.
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_W'(FILT_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall_edge = clk_filt_d & ~clk_filt;
    assign data_s    = data_sync[1];

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic              stop_evt, timeout_hit;
    logic [CNT_W-1:0]  to_cnt;
    logic [1:0]        byte_idx;

    assign timeout_hit = enable && !fall_edge && (to_cnt == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        stop_evt  = 1'b0;
        if (!enable || timeout_hit) begin
            state_d = IDLE;
        end else if (fall_edge) begin
            case (state_q)
                IDLE: if (!data_s) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
                DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                default: begin
                    stop_evt = 1'b1;
                    state_d  = IDLE;
                end
            endcase
        end
    end

    logic parity_ok, perr, ferr, byte_ok;
    assign parity_ok = ^{shift_q, par_q};
    assign perr      = stop_evt && !parity_ok;
    assign ferr      = stop_evt && parity_ok && !data_s;
    assign byte_ok   = stop_evt && parity_ok && data_s;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt <= '0;
        end else if (!enable || fall_edge || timeout_hit || (state_q == IDLE && byte_idx == 2'd0)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Packet being completed: stored bytes with the just-received byte in its slot.
    logic [7:0] bytes_q [0:3];
    logic [7:0] pkt     [0:3];
    logic       last_byte, store_byte;

    assign last_byte  = (byte_idx == 2'(PKT_BYTES - 1));
    assign store_byte = byte_ok && enable && (byte_idx != 2'd0 || shift_q[3]);

    always_comb begin
        for (int i = 0; i < 4; i++) pkt[i] = bytes_q[i];
        pkt[byte_idx] = shift_q;
    end

    // NOTE: the byte buffer is written before it is read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (store_byte) bytes_q[byte_idx] <= shift_q;
    end

    logic signed [8:0]    dx_new, dy_new;
    logic [3:0]           wheel_new;
    logic signed [SW-1:0] x_sum, y_sum;
    logic [POS_W-1:0]     x_new, y_new;

    always_comb begin
        dx_new    = pkt[0][6] ? 9'sd0 : {pkt[0][4], pkt[1]};
        dy_new    = pkt[0][7] ? 9'sd0 : {pkt[0][5], pkt[2]};
        wheel_new = (PKT_BYTES == 4) ? pkt[3][3:0] : 4'd0;
        x_sum     = $signed({2'b00, x_pos}) + SW'(dx_new);
        y_sum     = $signed({2'b00, y_pos}) - SW'(dy_new);
        if (x_sum < 0)          x_new = '0;
        else if (x_sum > X_LIM) x_new = POS_W'(X_MAX);
        else                    x_new = x_sum[POS_W-1:0];
        if (y_sum < 0)          y_new = '0;
        else if (y_sum > Y_LIM) y_new = POS_W'(Y_MAX);
        else                    y_new = y_sum[POS_W-1:0];
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, pkt[0][3], pkt[3][7:4], bit_cnt_q};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_idx    <= 2'd0;
            pkt_valid   <= 1'b0;
            buttons     <= '0;
            dx          <= '0;
            dy          <= '0;
            wheel       <= '0;
            x_pos       <= POS_W'(X_MAX >> 1);
            y_pos       <= POS_W'(Y_MAX >> 1);
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            pkt_valid   <= 1'b0;
            err_parity  <= perr;
            err_frame   <= ferr;
            err_timeout <= timeout_hit;
            if (!enable || perr || ferr || timeout_hit) begin
                byte_idx <= 2'd0;
            end else if (store_byte) begin
                if (last_byte) begin
                    byte_idx  <= 2'd0;
                    pkt_valid <= 1'b1;
                    buttons   <= pkt[0][2:0];
                    dx        <= dx_new;
                    dy        <= dy_new;
                    wheel     <= wheel_new;
                    x_pos     <= x_new;
                    y_pos     <= y_new;
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx: 3-byte and 4-byte instances share the PS/2 lines,
// only one is enabled at a time; a byte-stream model predicts packets and errors.
module tb_ps2_mouse_rx;
    localparam int TO   = 2000;
    localparam int HALF = 20;
    localparam int GAP  = 60;

    typedef struct packed {
        logic        d;
        logic [2:0]  buttons;
        logic [8:0]  dx;
        logic [8:0]  dy;
        logic [3:0]  wheel;
        logic [15:0] x;
        logic [15:0] y;
    } pkt_t;

    logic clk = 1'b0, rstn = 1'b0, en3 = 1'b0, en4 = 1'b0;
    logic ps2_clk = 1'b1, ps2_data = 1'b1;
    logic pv3, pv4, ep3, ep4, ef3, ef4, et3, et4;
    logic [2:0] btn3, btn4;
    logic [8:0] dx3, dx4, dy3, dy4;
    logic [3:0] wh3, wh4;
    logic [15:0] x3, x4, y3, y4;

    always #5 clk = ~clk;

    ps2_mouse_rx #(.PKT_BYTES(3), .TIMEOUT_CYC(TO)) dut3 (
        .clk(clk), .rstn(rstn), .enable(en3), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .pkt_valid(pv3), .buttons(btn3), .dx(dx3), .dy(dy3), .wheel(wh3),
        .x_pos(x3), .y_pos(y3), .err_parity(ep3), .err_frame(ef3), .err_timeout(et3));

    ps2_mouse_rx #(.PKT_BYTES(4), .TIMEOUT_CYC(TO)) dut4 (
        .clk(clk), .rstn(rstn), .enable(en4), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .pkt_valid(pv4), .buttons(btn4), .dx(dx4), .dy(dy4), .wheel(wh4),
        .x_pos(x4), .y_pos(y4), .err_parity(ep4), .err_frame(ef4), .err_timeout(et4));

    int checks = 0, errors = 0;
    pkt_t got_q[$], exp_q[$];
    int got_perr = 0, got_ferr = 0, got_to = 0;
    int exp_perr = 0, exp_ferr = 0, exp_to = 0;

    int m_idx [2];
    int m_x [2];
    int m_y [2];
    logic [7:0] m_b [2][4];

    function automatic pkt_t mk(input logic d, input logic [2:0] b, input logic [8:0] x_d,
                                input logic [8:0] y_d, input logic [3:0] w,
                                input logic [15:0] x, input logic [15:0] y);
        pkt_t p;
        p.d = d; p.buttons = b; p.dx = x_d; p.dy = y_d; p.wheel = w; p.x = x; p.y = y;
        return p;
    endfunction

    always @(negedge clk) begin
        if (pv3) got_q.push_back(mk(1'b0, btn3, dx3, dy3, wh3, x3, y3));
        if (pv4) got_q.push_back(mk(1'b1, btn4, dx4, dy4, wh4, x4, y4));
        if (ep3 || ep4) got_perr++;
        if (ef3 || ef4) got_ferr++;
        if (et3 || et4) got_to++;
    end

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    // Reference: interpret the byte stream as the mouse protocol describes it.
    task automatic model_byte(input int d, input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int n, mdx, mdy, mw;
        n = (d == 1) ? 4 : 3;
        if (bad_par) begin
            exp_perr++;
            m_idx[d] = 0;
        end else if (bad_stop) begin
            exp_ferr++;
            m_idx[d] = 0;
        end else if (!(m_idx[d] == 0 && !b[3])) begin
            m_b[d][m_idx[d]] = b;
            m_idx[d]++;
            if (m_idx[d] == n) begin
                mdx = m_b[d][0][6] ? 0 : int'(m_b[d][1]) - (m_b[d][0][4] ? 256 : 0);
                mdy = m_b[d][0][7] ? 0 : int'(m_b[d][2]) - (m_b[d][0][5] ? 256 : 0);
                mw  = (d == 1) ? int'(m_b[d][3][3:0]) - (m_b[d][3][3] ? 16 : 0) : 0;
                m_x[d] = clampi(m_x[d] + mdx, 639);
                m_y[d] = clampi(m_y[d] - mdy, 479);
                exp_q.push_back(mk(d[0], m_b[d][0][2:0], 9'(mdx), 9'(mdy), 4'(mw),
                                   16'(m_x[d]), 16'(m_y[d])));
                m_idx[d] = 0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = f[i];
            if (glitch) begin
                repeat (HALF / 2) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (2) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (HALF / 2 - 2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
        if (en3 || en4) model_byte(en4 ? 1 : 0, b, bad_par, bad_stop);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            m_idx[d] = 0; m_x[d] = 319; m_y[d] = 239;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({x3, y3} !== {16'd319, 16'd239}) begin errors++;
            $display("FAIL reset_pos3 got %0d,%0d exp 319,239", x3, y3); end
        checks++; if ({x4, y4} !== {16'd319, 16'd239}) begin errors++;
            $display("FAIL reset_pos4 got %0d,%0d exp 319,239", x4, y4); end
        checks++; if ({btn3, dx3, dy3, wh3} !== 25'd0) begin errors++;
            $display("FAIL reset_fields3 got %h exp 0", {btn3, dx3, dy3, wh3}); end
        checks++; if ({pv3, ep3, ef3, et3, pv4, ep4, ef4, et4} !== 8'd0) begin errors++;
            $display("FAIL reset_pulses got %b exp 0", {pv3, ep3, ef3, et3, pv4, ep4, ef4, et4}); end
    endtask

    task automatic test_basic();
        pkt_t p, e;
        do_reset();
        en3 = 1'b1;
        send_byte(8'h09, 0, 0, 0); send_byte(8'h05, 0, 0, 0); send_byte(8'h03, 0, 0, 0);
        checks++; if (got_q.size() !== 1) begin errors++;
            $display("FAIL basic_count got %0d exp 1", got_q.size()); end
        checks++; if ({btn3, dx3, dy3, x3, y3} !== {3'b001, 9'd5, 9'd3, 16'd324, 16'd236}) begin errors++;
            $display("FAIL basic_decode got btn=%b dx=%0d dy=%0d x=%0d y=%0d exp 001 5 3 324 236",
                     btn3, $signed(dx3), $signed(dy3), x3, y3); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            p = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (p !== e) begin errors++; $display("FAIL basic_pkt got %h exp %h", p, e); end
        end
    endtask

    task automatic test_clamp();
        pkt_t p, e;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            send_byte(8'h18, 0, 0, 0); send_byte(8'h00, 0, 0, 0); send_byte(8'h00, 0, 0, 0);
            checks++; if (x3 !== ((k == 0) ? 16'd63 : 16'd0)) begin errors++;
                $display("FAIL clamp_x%0d got %0d exp %0d", k, x3, (k == 0) ? 63 : 0); end
        end
        checks++; if ({dx3, y3} !== {9'h100, 16'd239}) begin errors++;
            $display("FAIL clamp_dxy got dx=%0d y=%0d exp -256 239", $signed(dx3), y3); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++;
            $display("FAIL clamp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            p = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (p !== e) begin errors++; $display("FAIL clamp_pkt got %h exp %h", p, e); end
        end
    endtask

    task automatic test_errors();
        pkt_t p, e;
        send_byte(8'h08, 0, 0, 0); send_byte(8'h05, 1, 0, 0);
        send_byte(8'h08, 0, 0, 0); send_byte(8'h01, 0, 0, 0); send_byte(8'h01, 0, 0, 0);
        checks++; if ({dx3, dy3} !== {9'd1, 9'd1}) begin errors++;
            $display("FAIL parity_recover got dx=%0d dy=%0d exp 1 1", $signed(dx3), $signed(dy3)); end
        send_byte(8'h00, 0, 0, 0);
        send_byte(8'h08, 0, 0, 0); send_byte(8'h02, 0, 0, 0); send_byte(8'h00, 0, 0, 0);
        checks++; if (dx3 !== 9'd2) begin errors++;
            $display("FAIL resync_dx got %0d exp 2", $signed(dx3)); end
        send_byte(8'h08, 0, 1, 0);
        send_byte(8'h08, 0, 0, 0); send_byte(8'h07, 0, 0, 0); send_byte(8'h00, 0, 0, 0);
        checks++; if ({got_perr, got_ferr} !== {exp_perr, exp_ferr}) begin errors++;
            $display("FAIL err_counts got p=%0d f=%0d exp p=%0d f=%0d", got_perr, got_ferr, exp_perr, exp_ferr); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++;
            $display("FAIL errors_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            p = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (p !== e) begin errors++; $display("FAIL errors_pkt got %h exp %h", p, e); end
        end
    endtask

    task automatic test_timeout_enable();
        pkt_t p, e;
        send_byte(8'h08, 0, 0, 0); send_byte(8'h05, 0, 0, 0);
        repeat (TO + 5) @(negedge clk);
        exp_to++; m_idx[0] = 0;
        checks++; if (got_to !== exp_to) begin errors++;
            $display("FAIL timeout_pulse got %0d exp %0d", got_to, exp_to); end
        send_byte(8'h08, 0, 0, 0); send_byte(8'h01, 0, 0, 0); send_byte(8'h00, 0, 0, 0);
        checks++; if (dx3 !== 9'd1) begin errors++;
            $display("FAIL timeout_recover got dx=%0d exp 1", $signed(dx3)); end
        send_byte(8'h08, 0, 0, 0); send_byte(8'h05, 0, 0, 0);
        en3 = 1'b0; repeat (5) @(negedge clk); en3 = 1'b1;
        m_idx[0] = 0;
        send_byte(8'h08, 0, 0, 0); send_byte(8'h03, 0, 0, 0); send_byte(8'h04, 0, 0, 0);
        repeat (TO + 5) @(negedge clk);
        checks++; if ({got_to, got_perr, got_ferr} !== {exp_to, exp_perr, exp_ferr}) begin errors++;
            $display("FAIL enable_errs got to=%0d p=%0d f=%0d exp %0d %0d %0d",
                     got_to, got_perr, got_ferr, exp_to, exp_perr, exp_ferr); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++;
            $display("FAIL timeout_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            p = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (p !== e) begin errors++; $display("FAIL timeout_pkt got %h exp %h", p, e); end
        end
    endtask

    task automatic test_random();
        pkt_t p, e;
        logic [7:0] b;
        bit bp, bs;
        for (int k = 0; k < 36; k++) begin
            b  = 8'($urandom);
            if ($urandom_range(0, 7) != 0 && (k % 3) == 0) b[3] = 1'b1;
            bp = ($urandom_range(0, 11) == 0);
            bs = !bp && ($urandom_range(0, 11) == 0);
            send_byte(b, bp, bs, 0);
        end
        checks++; if ({got_perr, got_ferr} !== {exp_perr, exp_ferr}) begin errors++;
            $display("FAIL random_errs got p=%0d f=%0d exp p=%0d f=%0d", got_perr, got_ferr, exp_perr, exp_ferr); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++;
            $display("FAIL random_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            p = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (p !== e) begin errors++; $display("FAIL random_pkt got %h exp %h", p, e); end
        end
    endtask

    task automatic test_wheel();
        pkt_t p, e;
        logic [7:0] b0;
        do_reset();
        en3 = 1'b0; en4 = 1'b1;
        send_byte(8'h48, 0, 0, 1); send_byte(8'h7F, 0, 0, 1);
        send_byte(8'h02, 0, 0, 1); send_byte(8'h0F, 0, 0, 1);
        checks++; if ({dx4, dy4, wh4} !== {9'd0, 9'd2, 4'hF}) begin errors++;
            $display("FAIL wheel_decode got dx=%0d dy=%0d w=%0d exp 0 2 -1",
                     $signed(dx4), $signed(dy4), $signed(wh4)); end
        for (int k = 0; k < 4; k++) begin
            b0 = 8'($urandom); b0[3] = 1'b1;
            send_byte(b0, 0, 0, 0);
            for (int j = 0; j < 3; j++) send_byte(8'($urandom), 0, 0, k[0]);
        end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++;
            $display("FAIL wheel_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            p = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (p !== e) begin errors++; $display("FAIL wheel_pkt got %h exp %h", p, e); end
        end
        checks++; if (got_perr + got_ferr + got_to !== exp_perr + exp_ferr + exp_to) begin errors++;
            $display("FAIL wheel_errs got %0d exp %0d", got_perr + got_ferr + got_to,
                     exp_perr + exp_ferr + exp_to); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_errors();
        test_timeout_enable();
        test_random();
        test_wheel();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
